mvm_y_serializer: RTL and testbench
===================================

# mvm_y_serializer

Downstream output stage of the MVM UART system. Accepts one complete result vector of R signed W_Y_OUT-bit outputs from the MVM core over a valid/ready handshake and emits it as a stream of BITS_PER_WORD-bit words, one per handshake, into the UART transmitter. It buffers one full vector, so the core can return to computing while the slow UART drains bytes.

## Interface

Parameters:
- R, 8, number of output elements per vector
- W_Y_OUT, 32, width of each output element; must be an integer multiple of BITS_PER_WORD
- BITS_PER_WORD, 8, width of each emitted word (UART payload)
- Derived: BYTES_PER_Y = W_Y_OUT/BITS_PER_WORD; N_WORDS = R*BYTES_PER_Y (32 at defaults)

Ports:
- clk  in  1  sole clock; all logic is on the rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input vector valid
- s_ready  out  1  serializer can accept a vector
- s_data  in  [R-1:0][W_Y_OUT-1:0]  result vector; element 0 is s_data[0]
- m_valid  out  1  output word valid
- m_ready  in  1  UART transmitter accepts the word
- m_data  out  BITS_PER_WORD  output word

## Operation

- Two states: IDLE and SEND. Reset forces IDLE.
- IDLE: s_ready=1, m_valid=0. On s_valid&&s_ready, load the flattened s_data into an R*W_Y_OUT-bit shift register, clear the word counter to 0, and go to SEND.
- Flattening order: element 0 first; within an element, least-significant word first. Word k of the frame = bits [k*BITS_PER_WORD +: BITS_PER_WORD] of {s_data[R-1],…,s_data[0]}.
- SEND: s_ready=0, m_valid=1, m_data = low BITS_PER_WORD bits of the shift register.
- On m_valid&&m_ready in SEND: shift the register right by BITS_PER_WORD (zero fill). If counter==N_WORDS-1, go to IDLE; otherwise increment the counter.
- m_valid&&!m_ready: hold m_data and the counter unchanged (stable until accepted).
- s_data/s_valid are ignored in SEND; changes to s_data after acceptance do not affect the frame in flight.
- Counter width: $clog2(N_WORDS) bits; it never wraps past N_WORDS-1.
- The block performs no arithmetic on the data; sign bits are transmitted verbatim.

## Timing

- Reset values: m_valid=0, m_data=0, state=IDLE (so s_ready=1), counter=0, shift register=0.
- s_ready is decoded directly from state (state==IDLE), so it reads 1 whenever rst is asserted.
- m_valid and m_data are registered.
- Latency: vector accepted on edge T produces m_valid=1 with word 0 immediately after edge T, so the word is presented in cycle T+1.
- Throughput: with m_ready held high, one word per cycle. A frame occupies N_WORDS SEND cycles followed by one IDLE cycle.
- Back-to-back frames: with s_valid held high, the next vector is accepted on the edge after the IDLE cycle that follows the last word. This gives exactly one bubble cycle (m_valid=0) between frames.
- Last-word handshake and new s_valid in the same cycle: the new vector is not accepted in that cycle, because s_ready=0 there.
- Reset mid-frame: the frame is abandoned immediately (asynchronous). m_valid drops to 0 without waiting for the clock, the remaining words are discarded, and the block is ready in IDLE.

## Test plan

- Reset: assert rst with s_valid=1 and m_ready=1 -> m_valid=0, m_data=0, s_ready=1 throughout. No word is emitted after release until a new handshake.
- Single frame: s_data[i] = {4i+4, 4i+3, 4i+2, 4i+1} (bytes, so s_data[0]=0x04030201 … s_data[7]=0x201F1E1D), m_ready=1 -> words 0x01,0x02,…,0x20 on 32 consecutive cycles starting one cycle after acceptance. s_ready=0 for those 32 cycles, then 1.
- Backpressure: same frame with m_ready toggled in a pseudo-random pattern (including 10-cycle low stretches) -> identical word sequence. m_data is stable while m_valid&&!m_ready, and exactly 32 handshakes occur.
- Back-to-back: s_valid held high with frames A (all 0xAA bytes) and B (all 0x55 bytes) -> 32×0xAA, exactly one m_valid=0 cycle, then 32×0x55.
- Input isolation: change s_data to all 0xFF one cycle after acceptance -> the emitted frame still matches the originally latched vector.
- Reset mid-frame: assert rst asynchronously after 5 word handshakes, then start a new frame -> m_valid falls without waiting for a clock edge. The new frame starts at its own word 0, with no leftover words from the aborted frame.

Source files
------------

// File: rtl/mvm_y_serializer.sv
// Output stage of the MVM UART system: buffers one result vector and emits it
// as a stream of BITS_PER_WORD-bit words over a valid/ready handshake.
module mvm_y_serializer #(
    parameter int R             = 8,
    parameter int W_Y_OUT       = 32,
    parameter int BITS_PER_WORD = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [R-1:0][W_Y_OUT-1:0]     s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [BITS_PER_WORD-1:0]      m_data
);

    localparam int BYTES_PER_Y = W_Y_OUT / BITS_PER_WORD;
    localparam int N_WORDS     = R * BYTES_PER_Y;
    localparam int FRAME_W     = R * W_Y_OUT;
    localparam int CNT_W       = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                     state;
    state_t                     next_state;
    logic [FRAME_W-1:0]         shreg;
    logic [FRAME_W-1:0]         shreg_next;
    logic [CNT_W-1:0]           cnt;
    logic [CNT_W-1:0]           cnt_next;
    logic                       m_valid_next;
    logic [BITS_PER_WORD-1:0]   m_data_next;

    // s_ready comes straight from state so it reads 1 while rst is held
    assign s_ready = (state == IDLE);

    // Next-state, frame buffer and word counter; m_valid/m_data are precomputed
    // from the next values so the registered outputs line up with the state.
    always_comb begin
        next_state = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    next_state = SEND;
                    shreg_next = s_data;
                    cnt_next   = {CNT_W{1'b0}};
                end else begin
                    next_state = IDLE;
                end
            end
            SEND: begin
                if (m_ready) begin
                    shreg_next = shreg >> BITS_PER_WORD;
                    if (cnt == LAST_WORD) begin
                        next_state = IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else begin
                    next_state = SEND;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        m_valid_next = (next_state == SEND);
        m_data_next  = shreg_next[BITS_PER_WORD-1:0];
    end

    // State, frame buffer and registered output word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= {FRAME_W{1'b0}};
            cnt     <= {CNT_W{1'b0}};
            m_valid <= 1'b0;
            m_data  <= {BITS_PER_WORD{1'b0}};
        end else begin
            state   <= next_state;
            shreg   <= shreg_next;
            cnt     <= cnt_next;
            m_valid <= m_valid_next;
            m_data  <= m_data_next;
        end
    end

endmodule

// File: tb/tb_mvm_y_serializer.sv
// Directed self-checking bench for mvm_y_serializer: reset, single frame,
// backpressure, back-to-back frames, input isolation and mid-frame reset.
module tb_mvm_y_serializer;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [7:0][31:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_data;

    int errors = 0;
    int checks = 0;

    mvm_y_serializer #(.R(8), .W_Y_OUT(32), .BITS_PER_WORD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // kind 0: counting bytes 0x01..0x20, kind 1: 0xAA, kind 2: 0x55
    function automatic logic [7:0] exp_word(input int kind, input int k);
        case (kind)
            0:       return 8'(k + 1);
            1:       return 8'hAA;
            2:       return 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    task automatic load_counting();
        for (int i = 0; i < 8; i++)
            s_data[i] = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance
    task automatic start_frame();
        check("start_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Called at the first negedge after acceptance; consumes 32 words, then
    // returns at the bubble negedge after checking it
    task automatic run_frame(input string tag, input int kind, input int bp);
        int hs;
        int cyc;
        hs  = 0;
        cyc = 0;
        while (hs < 32 && cyc < 400) begin
            if (bp == 0)
                m_ready = 1'b1;
            else if ((cyc >= 3 && cyc < 13) || (cyc >= 30 && cyc < 40))
                m_ready = 1'b0;
            else
                m_ready = ($urandom_range(0, 2) != 0);
            check({tag, "_m_valid"}, 32'(m_valid), 32'd1);
            check({tag, "_m_data"},  32'(m_data),  32'(exp_word(kind, hs)));
            check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
            if (m_valid && m_ready) hs++;
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        check({tag, "_handshakes"}, 32'(hs), 32'd32);
        check({tag, "_bubble_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_bubble_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        load_counting();
        #1 rst = 1'b1;

        // Reset held with s_valid and m_ready high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_m_data",  32'(m_data),  32'd0);
            check("rst_s_ready", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_m_valid", 32'(m_valid), 32'd0);
        end

        // Single frame, m_ready high
        start_frame();
        run_frame("single", 0, 0);
        @(negedge clk);

        // Same frame under backpressure
        start_frame();
        run_frame("bp", 0, 1);
        @(negedge clk);

        // Back-to-back frames with s_valid held high
        s_data = {8{32'hAAAA_AAAA}};
        s_valid = 1'b1;
        @(negedge clk);
        s_data = {8{32'h5555_5555}};
        run_frame("b2b_a", 1, 0);
        @(negedge clk);
        s_valid = 1'b0;
        run_frame("b2b_b", 2, 0);
        @(negedge clk);

        // Input changes after acceptance must not reach the frame
        load_counting();
        start_frame();
        s_data = {8{32'hFFFF_FFFF}};
        run_frame("iso", 0, 0);
        @(negedge clk);

        // Asynchronous reset after five handshakes
        load_counting();
        start_frame();
        for (int k = 0; k < 5; k++) begin
            check("mid_m_data", 32'(m_data), 32'(exp_word(0, k)));
            @(negedge clk);
        end
        check("mid_pre_rst_m_data", 32'(m_data), 32'h06);
        #2 rst = 1'b1;
        #1;
        check("async_m_valid", 32'(m_valid), 32'd0);
        check("async_m_data",  32'(m_data),  32'd0);
        check("async_s_ready", 32'(s_ready), 32'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_abort_m_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("after_abort_m_valid2", 32'(m_valid), 32'd0);
        start_frame();
        run_frame("restart", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
